// File: rtl/dmem_param_if.sv
// rtl/dmem_param_if.sv - Load/store bus between the control unit and dmem_param.
interface dmem_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              Init_Req;
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Write_Data;
    logic [DATA_W-1:0] Read_Data;
    logic              Read_Valid;
    logic              Busy;
    logic              Addr_Err;

    modport master (
        output Init_Req, MemRead, MemWrite, Address, Write_Data,
        input  Read_Data, Read_Valid, Busy, Addr_Err
    );

    modport slave (
        input  Init_Req, MemRead, MemWrite, Address, Write_Data,
        output Read_Data, Read_Valid, Busy, Addr_Err
    );
endinterface

// File: rtl/dmem_param.sv
// rtl/dmem_param.sv - Parametrised data memory with registered read and preset init sequencer.
module dmem_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic         Clk,
    input  logic         Clear_n,
    dmem_param_if.slave  bus
);
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    localparam logic [CNT_W-1:0]  HALF_C  = CNT_W'(DEPTH / 2);
    localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] HALF_DC = DATA_W'(DEPTH / 2);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;

    logic              accept;
    logic              in_range;
    logic [CNT_W-1:0]  idx;
    logic [DATA_W-1:0] cnt_ext;
    logic [DATA_W-1:0] init_val;
    logic              init_we;
    logic              acc_we;

    // Wide compare so that every address >= DEPTH is an error, no aliasing.
    assign in_range = ({1'b0, bus.Address} < DEPTH_C);
    assign idx      = bus.Address[CNT_W-1:0];
    assign accept   = (state_q == ST_IDLE) && !bus.Init_Req;

    // Lower half counts up from 0, upper half counts down from 0 (mod 2^DATA_W).
    assign cnt_ext  = DATA_W'(cnt_q);
    assign init_val = (cnt_q < HALF_C) ? cnt_ext : (DATA_W'(0) - (cnt_ext - HALF_DC));

    assign init_we  = (state_q == ST_INIT);
    assign acc_we   = accept && bus.MemWrite && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.Init_Req) begin
            state_d = ST_INIT;
            cnt_d   = '0;
        end else if (state_q == ST_INIT) begin
            if (cnt_q == LAST_C) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Read samples the array before this edge's write lands: read-first.
    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;
        if (accept) begin
            rd_valid_d = bus.MemRead;
            addr_err_d = (bus.MemRead || bus.MemWrite) && !in_range;
            if (bus.MemRead && in_range) begin
                rd_data_d = mem[idx];
            end
        end
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Array has no reset; its contents are defined only by the init sequence.
    always_ff @(posedge Clk) begin
        if (init_we) begin
            mem[cnt_q] <= init_val;
        end else if (acc_we) begin
            mem[idx] <= bus.Write_Data;
        end
    end

    assign bus.Read_Data  = rd_data_q;
    assign bus.Read_Valid = rd_valid_q;
    assign bus.Busy       = (state_q == ST_INIT);
    assign bus.Addr_Err   = addr_err_q;
endmodule

// File: tb/tb_dmem_param.sv
// tb/tb_dmem_param.sv - Randomised self-checking bench for dmem_param against a word-array model.
module tb_dmem_param;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 32;

    logic clk;
    logic clear_n;
    int   checks;
    int   errors;

    logic [DATA_W-1:0] model [DEPTH];

    dmem_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clk     (clk),
        .Clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pattern(input int i);
        if (i < DEPTH / 2) return DATA_W'(i);
        return DATA_W'(0 - (i - DEPTH / 2));
    endfunction

    task automatic load_model();
        for (int i = 0; i < DEPTH; i++) model[i] = pattern(i);
    endtask

    task automatic drive(input logic ir, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        bus.Init_Req   = ir;
        bus.MemRead    = rd;
        bus.MemWrite   = wr;
        bus.Address    = a;
        bus.Write_Data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        bus.Init_Req = 0; bus.MemRead = 0; bus.MemWrite = 0;
        while (bus.Busy === 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        clear_n = 1'b0;
        bus.Init_Req = 0; bus.MemRead = 0; bus.MemWrite = 0;
        bus.Address = '0; bus.Write_Data = '0;
        #1;
        checks++;
        if (bus.Busy !== 1'b1 || bus.Read_Valid !== 1'b0 || bus.Read_Data !== '0 || bus.Addr_Err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rv=%b rd=%h ae=%b required 1 0 00 0",
                     bus.Busy, bus.Read_Valid, bus.Read_Data, bus.Addr_Err);
        end
        repeat (2) @(posedge clk);
        #1;
        clear_n = 1'b1;
        wait_init(n);
        checks++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL init_edges: got %0d required %0d", n, DEPTH);
        end
        load_model();
    endtask

    task automatic test_init_pattern();
        int addrs [6] = '{0, 5, 15, 16, 17, 31};
        logic [DATA_W-1:0] exp_v [6] = '{8'h00, 8'h05, 8'h0f, 8'h00, 8'hff, 8'hf1};
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 0, ADDR_W'(addrs[k]), '0);
            checks++;
            if (bus.Read_Valid !== 1'b1 || bus.Read_Data !== exp_v[k]) begin
                errors++;
                $display("FAIL init_read addr=%0d: rv=%b rd=%h required 1 %h",
                         addrs[k], bus.Read_Valid, bus.Read_Data, exp_v[k]);
            end
            drive(0, 0, 0, '0, '0);
            checks++;
            if (bus.Read_Valid !== 1'b0 || bus.Read_Data !== '0) begin
                errors++;
                $display("FAIL read_idle addr=%0d: rv=%b rd=%h required 0 00",
                         addrs[k], bus.Read_Valid, bus.Read_Data);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 0, ADDR_W'(i), '0);
            checks++;
            if (bus.Read_Data !== model[i]) begin
                errors++;
                $display("FAIL init_sweep addr=%0d: rd=%h required %h", i, bus.Read_Data, model[i]);
            end
        end
        drive(0, 0, 0, '0, '0);
    endtask

    task automatic test_busy_ignore();
        int n;
        drive(1, 0, 0, '0, '0);
        drive(0, 1, 1, 8'd3, 8'haa);
        checks++;
        if (bus.Read_Valid !== 1'b0 || bus.Read_Data !== '0 || bus.Addr_Err !== 1'b0 || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_ignore: rv=%b rd=%h ae=%b busy=%b required 0 00 0 1",
                     bus.Read_Valid, bus.Read_Data, bus.Addr_Err, bus.Busy);
        end
        wait_init(n);
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL busy_ignore_timeout: busy still %b", bus.Busy);
        end
        load_model();
        drive(0, 1, 0, 8'd3, '0);
        checks++;
        if (bus.Read_Valid !== 1'b1 || bus.Read_Data !== 8'h03) begin
            errors++;
            $display("FAIL busy_write_dropped: rv=%b rd=%h required 1 03", bus.Read_Valid, bus.Read_Data);
        end
        drive(0, 0, 0, '0, '0);
    endtask

    task automatic test_read_first();
        drive(0, 1, 1, 8'd7, 8'h5a);
        checks++;
        if (bus.Read_Valid !== 1'b1 || bus.Read_Data !== 8'h07) begin
            errors++;
            $display("FAIL read_first_old: rv=%b rd=%h required 1 07", bus.Read_Valid, bus.Read_Data);
        end
        model[7] = 8'h5a;
        drive(0, 1, 0, 8'd7, '0);
        checks++;
        if (bus.Read_Data !== 8'h5a) begin
            errors++;
            $display("FAIL read_first_new: rd=%h required 5a", bus.Read_Data);
        end
        drive(0, 0, 0, '0, '0);
    endtask

    task automatic test_out_of_range();
        drive(0, 0, 1, 8'd32, 8'h11);
        checks++;
        if (bus.Addr_Err !== 1'b1 || bus.Read_Valid !== 1'b0) begin
            errors++;
            $display("FAIL oor_write: ae=%b rv=%b required 1 0", bus.Addr_Err, bus.Read_Valid);
        end
        drive(0, 1, 0, 8'd32, '0);
        checks++;
        if (bus.Addr_Err !== 1'b1 || bus.Read_Valid !== 1'b1 || bus.Read_Data !== '0) begin
            errors++;
            $display("FAIL oor_read: ae=%b rv=%b rd=%h required 1 1 00",
                     bus.Addr_Err, bus.Read_Valid, bus.Read_Data);
        end
        drive(0, 1, 1, 8'd255, 8'h77);
        checks++;
        if (bus.Addr_Err !== 1'b1 || bus.Read_Data !== '0) begin
            errors++;
            $display("FAIL oor_both: ae=%b rd=%h required 1 00", bus.Addr_Err, bus.Read_Data);
        end
        drive(0, 0, 0, '0, '0);
        checks++;
        if (bus.Addr_Err !== 1'b0) begin
            errors++;
            $display("FAIL oor_pulse: ae=%b required 0", bus.Addr_Err);
        end
        drive(0, 1, 0, 8'd0, '0);
        checks++;
        if (bus.Read_Data !== model[0] || bus.Addr_Err !== 1'b0) begin
            errors++;
            $display("FAIL oor_alias: rd=%h ae=%b required %h 0", bus.Read_Data, bus.Addr_Err, model[0]);
        end
        drive(0, 0, 0, '0, '0);
    endtask

    task automatic test_random();
        logic rd, wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd, exp_rd;
        logic exp_rv, exp_ae, inr;
        for (int k = 0; k < 300; k++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(DEPTH, 255))
                                              : ADDR_W'($urandom_range(0, DEPTH - 1));
            wd = DATA_W'($urandom);
            inr    = (int'(a) < DEPTH);
            exp_rv = rd;
            exp_rd = (rd && inr) ? model[int'(a)] : '0;
            exp_ae = (rd || wr) && !inr;
            if (wr && inr) model[int'(a)] = wd;
            drive(0, rd, wr, a, wd);
            checks++;
            if (bus.Read_Valid !== exp_rv || bus.Read_Data !== exp_rd || bus.Addr_Err !== exp_ae) begin
                errors++;
                $display("FAIL random k=%0d a=%0d rd=%b wr=%b: rv=%b data=%h ae=%b required %b %h %b",
                         k, a, rd, wr, bus.Read_Valid, bus.Read_Data, bus.Addr_Err, exp_rv, exp_rd, exp_ae);
            end
        end
        drive(0, 0, 0, '0, '0);
    endtask

    task automatic test_reinit();
        int n;
        drive(0, 0, 1, 8'd20, 8'hcc);
        drive(0, 1, 0, 8'd20, '0);
        checks++;
        if (bus.Read_Data !== 8'hcc) begin
            errors++;
            $display("FAIL reinit_pre: rd=%h required cc", bus.Read_Data);
        end
        drive(1, 0, 1, 8'd5, 8'h99);
        checks++;
        if (bus.Busy !== 1'b1 || bus.Read_Valid !== 1'b0) begin
            errors++;
            $display("FAIL reinit_enter: busy=%b rv=%b required 1 0", bus.Busy, bus.Read_Valid);
        end
        wait_init(n);
        checks++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL reinit_edges: got %0d required %0d", n, DEPTH);
        end
        load_model();
        drive(0, 1, 0, 8'd20, '0);
        checks++;
        if (bus.Read_Data !== 8'hfc) begin
            errors++;
            $display("FAIL reinit_value: rd=%h required fc", bus.Read_Data);
        end
        drive(0, 1, 0, 8'd5, '0);
        checks++;
        if (bus.Read_Data !== 8'h05) begin
            errors++;
            $display("FAIL reinit_req_write: rd=%h required 05", bus.Read_Data);
        end
        drive(0, 0, 0, '0, '0);
    endtask

    task automatic test_async_reset();
        int n;
        drive(0, 1, 0, 8'd9, '0);
        bus.MemRead = 0;
        #2;
        clear_n = 1'b0;
        #1;
        checks++;
        if (bus.Read_Valid !== 1'b0 || bus.Read_Data !== '0 || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL async_idle: rv=%b rd=%h busy=%b required 0 00 1",
                     bus.Read_Valid, bus.Read_Data, bus.Busy);
        end
        @(posedge clk);
        #1;
        clear_n = 1'b1;
        wait_init(n);
        load_model();
        drive(1, 0, 0, '0, '0);
        repeat (10) drive(0, 0, 0, '0, '0);
        drive(0, 0, 1, 8'd40, 8'h01);
        #2;
        checks++;
        if (bus.Addr_Err !== 1'b0 || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: ae=%b busy=%b required 0 1", bus.Addr_Err, bus.Busy);
        end
        clear_n = 1'b0;
        #1;
        checks++;
        if (bus.Busy !== 1'b1 || bus.Read_Valid !== 1'b0 || bus.Read_Data !== '0 || bus.Addr_Err !== 1'b0) begin
            errors++;
            $display("FAIL async_init: busy=%b rv=%b rd=%h ae=%b required 1 0 00 0",
                     bus.Busy, bus.Read_Valid, bus.Read_Data, bus.Addr_Err);
        end
        repeat (3) @(posedge clk);
        #1;
        clear_n = 1'b1;
        wait_init(n);
        checks++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL async_edges: got %0d required %0d", n, DEPTH);
        end
        load_model();
        drive(0, 1, 0, 8'd31, '0);
        checks++;
        if (bus.Read_Data !== model[31] || bus.Read_Valid !== 1'b1) begin
            errors++;
            $display("FAIL async_after: rd=%h rv=%b required %h 1", bus.Read_Data, bus.Read_Valid, model[31]);
        end
        drive(0, 0, 0, '0, '0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_init_pattern();
        test_busy_ignore();
        test_read_first();
        test_out_of_range();
        test_random();
        test_reinit();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
